// File: rtl/mult_step_counter.sv
// Iteration sequencer for the shift-add multiplier: counts STEPS enabled iterations
// up or down and reports step strobe, terminal flag, busy and a one-cycle done pulse.
module mult_step_counter #(
    parameter int unsigned CNT_W = 3,
    parameter int unsigned STEPS = 4,
    parameter bit          DOWN  = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             en,
    input  logic             abort,
    output logic [CNT_W-1:0] count,
    output logic             step,
    output logic             k,
    output logic             busy,
    output logic             done
);

    localparam longint unsigned MAX_STEPS = 64'd1 << CNT_W;

    if (CNT_W < 1 || STEPS < 2 || 64'(STEPS) > MAX_STEPS) begin : g_bad_steps
        $error("mult_step_counter: STEPS must lie in 2..2**CNT_W");
    end

    localparam logic [CNT_W-1:0] LAST = CNT_W'(STEPS - 1);
    localparam logic [CNT_W-1:0] INIT = DOWN ? LAST : '0;
    localparam logic [CNT_W-1:0] TERM = DOWN ? '0 : LAST;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            count_q <= INIT;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StRun;
                    count_d = INIT;
                end
            end
            StRun: begin
                // abort beats both the stall and the terminal transition
                if (abort) begin
                    state_d = StIdle;
                    count_d = INIT;
                end else if (en) begin
                    if (count_q == TERM) begin
                        state_d = StDone;
                        count_d = INIT;
                    end else if (DOWN) begin
                        count_d = count_q - CNT_W'(1);
                    end else begin
                        count_d = count_q + CNT_W'(1);
                    end
                end
            end
            StDone: begin
                state_d = start ? StRun : StIdle;
                count_d = INIT;
            end
            default: begin
                state_d = StIdle;
                count_d = INIT;
            end
        endcase
    end

    always_comb begin
        count = count_q;
        busy  = (state_q == StRun);
        done  = (state_q == StDone);
        step  = busy & en;
        k     = busy & (count_q == TERM);
    end

endmodule

// File: tb/tb_mult_step_counter.sv
// Self-checking bench for mult_step_counter: an up counter (STEPS=4) and a down counter
// (STEPS=5) driven from a vector table through an expectation queue.
module tb_mult_step_counter;

    typedef struct {
        bit       sel;    // 0: up instance, 1: down instance
        bit       start;
        bit       en;
        bit       abort;
        bit [2:0] count;
        bit       step;
        bit       k;
        bit       busy;
        bit       done;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       up_start = 1'b0, up_en = 1'b0, up_abort = 1'b0;
    logic       dn_start = 1'b0, dn_en = 1'b0, dn_abort = 1'b0;
    logic [2:0] up_count, dn_count;
    logic       up_step, up_k, up_busy, up_done;
    logic       dn_step, dn_k, dn_busy, dn_done;

    int n_asserts = 0;
    int n_fail    = 0;

    vec_t tbl[$];
    vec_t sb[$];
    int   t1_n, main_n;

    always #5 clk = ~clk;

    mult_step_counter #(.CNT_W(3), .STEPS(4), .DOWN(1'b0)) u_up (
        .clk   (clk),
        .rst   (rst),
        .start (up_start),
        .en    (up_en),
        .abort (up_abort),
        .count (up_count),
        .step  (up_step),
        .k     (up_k),
        .busy  (up_busy),
        .done  (up_done)
    );

    mult_step_counter #(.CNT_W(3), .STEPS(5), .DOWN(1'b1)) u_dn (
        .clk   (clk),
        .rst   (rst),
        .start (dn_start),
        .en    (dn_en),
        .abort (dn_abort),
        .count (dn_count),
        .step  (dn_step),
        .k     (dn_k),
        .busy  (dn_busy),
        .done  (dn_done)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_asserts++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input bit sel, input bit s, input bit e, input bit a, input bit [2:0] c,
                       input bit st, input bit kk, input bit b, input bit d);
        vec_t v;
        v.sel = sel; v.start = s; v.en = e; v.abort = a;
        v.count = c; v.step = st; v.k = kk; v.busy = b; v.done = d;
        tbl.push_back(v);
    endtask

    task automatic drive(input vec_t v);
        up_start = v.sel ? 1'b0 : v.start;
        up_en    = v.sel ? 1'b0 : v.en;
        up_abort = v.sel ? 1'b0 : v.abort;
        dn_start = v.sel ? v.start : 1'b0;
        dn_en    = v.sel ? v.en : 1'b0;
        dn_abort = v.sel ? v.abort : 1'b0;
    endtask

    task automatic apply(input int idx);
        vec_t e;
        @(posedge clk);
        #1;
        drive(tbl[idx]);
        sb.push_back(tbl[idx]);
        @(negedge clk);
        e = sb.pop_front();
        if (e.sel) begin
            check($sformatf("row%0d dn count", idx), 32'(dn_count), 32'(e.count));
            check($sformatf("row%0d dn step", idx), 32'(dn_step), 32'(e.step));
            check($sformatf("row%0d dn k", idx), 32'(dn_k), 32'(e.k));
            check($sformatf("row%0d dn busy", idx), 32'(dn_busy), 32'(e.busy));
            check($sformatf("row%0d dn done", idx), 32'(dn_done), 32'(e.done));
        end else begin
            check($sformatf("row%0d up count", idx), 32'(up_count), 32'(e.count));
            check($sformatf("row%0d up step", idx), 32'(up_step), 32'(e.step));
            check($sformatf("row%0d up k", idx), 32'(up_k), 32'(e.k));
            check($sformatf("row%0d up busy", idx), 32'(up_busy), 32'(e.busy));
            check($sformatf("row%0d up done", idx), 32'(up_done), 32'(e.done));
        end
    endtask

    initial begin
        //   sel s e a cnt st k b d
        // basic up run
        add(0, 1, 1, 0, 0, 0, 0, 0, 0);
        add(0, 0, 1, 0, 0, 1, 0, 1, 0);
        add(0, 0, 1, 0, 1, 1, 0, 1, 0);
        add(0, 0, 1, 0, 2, 1, 0, 1, 0);
        add(0, 0, 1, 0, 3, 1, 1, 1, 0);
        add(0, 0, 1, 0, 0, 0, 0, 0, 1);
        add(0, 0, 1, 0, 0, 0, 0, 0, 0);
        t1_n = tbl.size();
        // stall two cycles at count 1
        add(0, 1, 1, 0, 0, 0, 0, 0, 0);
        add(0, 0, 1, 0, 0, 1, 0, 1, 0);
        add(0, 0, 0, 0, 1, 0, 0, 1, 0);
        add(0, 0, 0, 0, 1, 0, 0, 1, 0);
        add(0, 0, 1, 0, 1, 1, 0, 1, 0);
        add(0, 0, 1, 0, 2, 1, 0, 1, 0);
        add(0, 0, 1, 0, 3, 1, 1, 1, 0);
        add(0, 0, 0, 0, 0, 0, 0, 0, 1);
        // k held through a stall at the terminal count
        add(0, 1, 1, 0, 0, 0, 0, 0, 0);
        add(0, 0, 1, 0, 0, 1, 0, 1, 0);
        add(0, 0, 1, 0, 1, 1, 0, 1, 0);
        add(0, 0, 1, 0, 2, 1, 0, 1, 0);
        add(0, 0, 0, 0, 3, 0, 1, 1, 0);
        add(0, 0, 0, 0, 3, 0, 1, 1, 0);
        add(0, 0, 1, 0, 3, 1, 1, 1, 0);
        add(0, 0, 0, 0, 0, 0, 0, 0, 1);
        // abort together with start at count 2
        add(0, 1, 1, 0, 0, 0, 0, 0, 0);
        add(0, 0, 1, 0, 0, 1, 0, 1, 0);
        add(0, 0, 1, 0, 1, 1, 0, 1, 0);
        add(0, 1, 1, 1, 2, 1, 0, 1, 0);
        add(0, 0, 1, 0, 0, 0, 0, 0, 0);
        add(0, 0, 1, 0, 0, 0, 0, 0, 0);
        // start held high; abort ignored in IDLE and DONE
        add(0, 1, 1, 1, 0, 0, 0, 0, 0);
        add(0, 1, 1, 0, 0, 1, 0, 1, 0);
        add(0, 1, 1, 0, 1, 1, 0, 1, 0);
        add(0, 1, 1, 0, 2, 1, 0, 1, 0);
        add(0, 1, 1, 0, 3, 1, 1, 1, 0);
        add(0, 1, 1, 1, 0, 0, 0, 0, 1);
        add(0, 1, 1, 0, 0, 1, 0, 1, 0);
        add(0, 1, 1, 0, 1, 1, 0, 1, 0);
        add(0, 1, 1, 0, 2, 1, 0, 1, 0);
        add(0, 1, 1, 0, 3, 1, 1, 1, 0);
        add(0, 0, 1, 0, 0, 0, 0, 0, 1);
        add(0, 0, 1, 0, 0, 0, 0, 0, 0);
        // down counter, STEPS=5
        add(1, 1, 1, 0, 4, 0, 0, 0, 0);
        add(1, 0, 1, 0, 4, 1, 0, 1, 0);
        add(1, 0, 1, 0, 3, 1, 0, 1, 0);
        add(1, 0, 1, 0, 2, 1, 0, 1, 0);
        add(1, 0, 1, 0, 1, 1, 0, 1, 0);
        add(1, 0, 1, 0, 0, 1, 1, 1, 0);
        add(1, 0, 1, 0, 4, 0, 0, 0, 1);
        add(1, 0, 1, 0, 4, 0, 0, 0, 0);
        main_n = tbl.size();
        // lead-in for the asynchronous reset case: up to count 2
        add(0, 1, 1, 0, 0, 0, 0, 0, 0);
        add(0, 0, 1, 0, 0, 1, 0, 1, 0);
        add(0, 0, 1, 0, 1, 1, 0, 1, 0);
        add(0, 0, 1, 0, 2, 1, 0, 1, 0);

        // reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst up count", 32'(up_count), 32'd0);
        check("rst dn count", 32'(dn_count), 32'd4);
        check("rst up outs", 32'({up_step, up_k, up_busy, up_done}), 32'd0);
        check("rst dn outs", 32'({dn_step, dn_k, dn_busy, dn_done}), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        for (int i = 0; i < main_n; i++) apply(i);

        // asynchronous reset mid-run, checked before the next edge
        for (int i = main_n; i < tbl.size(); i++) apply(i);
        #2;
        rst = 1'b1;
        #1;
        check("async rst count", 32'(up_count), 32'd0);
        check("async rst busy", 32'(up_busy), 32'd0);
        check("async rst step", 32'(up_step), 32'd0);
        check("async rst done", 32'(up_done), 32'd0);
        up_start = 1'b0;
        up_en    = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("post rst done", 32'(up_done), 32'd0);
        for (int i = 0; i < t1_n; i++) apply(i);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
